// File: rtl/conv_reader_pkg.sv
// rtl/conv_reader_pkg.sv - shared state encoding and default widths for the result reader
package conv_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int PSUM_WIDTH_DEF  = 17;
  localparam int COUNT_WIDTH_DEF = 8;

endpackage

// File: rtl/conv_result_reader_if.sv
// rtl/conv_result_reader_if.sv - downstream result stream bundle (valid/ready with index and last)
interface conv_result_reader_if
  import conv_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = PSUM_WIDTH_DEF,
  parameter int INDEX_WIDTH = COUNT_WIDTH_DEF
);

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous first-word fall-through FIFO, frozen while chip_en is low
module result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow are blocked here so a careless caller cannot corrupt the pointers.
  assign do_push = chip_en && push && !full;
  assign do_pop  = chip_en && pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/conv_result_reader.sv
// rtl/conv_result_reader.sv - drains accelerator results into a stream; RESULT_RELU_EN clamps negative outputs to zero
module conv_result_reader
  import conv_reader_pkg::*;
#(
  parameter int PSUM_WIDTH  = PSUM_WIDTH_DEF,
  parameter int DEPTH       = 64,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chip_en,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] expected_count,
  input  logic                   acc_psum_valid,
  input  logic [PSUM_WIDTH-1:0]  par_sum,
  input  logic                   acc_done,
  output logic                   read_buffer_result,
  conv_result_reader_if.master   out_if,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] total;
  logic [COUNT_WIDTH-1:0] pulled;
  logic [COUNT_WIDTH-1:0] pulled_nxt;
  logic [COUNT_WIDTH-1:0] index;
  logic                   idle_valid_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PSUM_WIDTH-1:0]  head;
  logic                   push;
  logic                   pop;
  logic                   start_ok;
  logic                   done_nxt;
  logic                   error_set;

  // The pop strobe depends on registered state only, so it never loops back through acc_psum_valid.
  assign read_buffer_result = (state == COLLECT) && !fifo_full && (pulled < total);
  assign push       = chip_en && read_buffer_result && acc_psum_valid;
  assign pop        = chip_en && out_if.out_valid && out_if.out_ready;
  assign start_ok   = (state == IDLE) && start && (expected_count != '0);
  assign pulled_nxt = push ? pulled + COUNT_WIDTH'(1) : pulled;
  assign busy       = (state != IDLE);

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_index = index;
  assign out_if.out_last  = !fifo_empty && (index == total - COUNT_WIDTH'(1));

  result_fifo #(
    .WIDTH (PSUM_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .chip_en (chip_en),
    .push    (push),
    .pop     (pop),
    .din     (par_sum),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Next-state, completion pulse and error detection for the run sequencer.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    error_set = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = COLLECT;
        end else if (start) begin
          done_nxt = 1'b1;
        end
        if (acc_psum_valid && idle_valid_q) error_set = 1'b1;
      end
      COLLECT: begin
        if (pulled_nxt == total) begin
          state_nxt = DRAIN;
        end else if (acc_done) begin
          state_nxt = DRAIN;
          error_set = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and the registered done pulse; everything freezes while chip_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else if (chip_en) begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Run counters, output ordinal and the sticky error flag; an accepted start clears all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      total        <= '0;
      pulled       <= '0;
      index        <= '0;
      error        <= 1'b0;
      idle_valid_q <= 1'b0;
    end else if (chip_en) begin
      idle_valid_q <= (state == IDLE) && acc_psum_valid;
      pulled       <= pulled_nxt;
      if (pop) index <= index + COUNT_WIDTH'(1);
      if (start_ok) begin
        total  <= expected_count;
        pulled <= '0;
        index  <= '0;
        error  <= 1'b0;
      end else if (error_set) begin
        error <= 1'b1;
      end
    end
  end

  // Output data stage: zero while empty, optionally clamping negative results.
  always_comb begin
    out_if.out_data = '0;
    if (!fifo_empty) begin
`ifdef RESULT_RELU_EN
      out_if.out_data = head[PSUM_WIDTH-1] ? '0 : head;
`else
      out_if.out_data = head;
`endif
    end
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// tb/tb_conv_result_reader.sv - self-checking bench for conv_result_reader against a stream reference model
module tb_conv_result_reader;
  import conv_reader_pkg::*;

  localparam int W  = PSUM_WIDTH_DEF;
  localparam int CW = COUNT_WIDTH_DEF;
  localparam int D  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          chip_en;
  logic          start;
  logic [CW-1:0] expected_count;
  logic          acc_psum_valid;
  logic [W-1:0]  par_sum;
  logic          acc_done;
  logic          read_buffer_result;
  logic          busy;
  logic          done;
  logic          error;

  conv_result_reader_if #(.DATA_WIDTH(W), .INDEX_WIDTH(CW)) out_if ();

  conv_result_reader #(
    .PSUM_WIDTH  (W),
    .DEPTH       (D),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .chip_en            (chip_en),
    .start              (start),
    .expected_count     (expected_count),
    .acc_psum_valid     (acc_psum_valid),
    .par_sum            (par_sum),
    .acc_done           (acc_done),
    .read_buffer_result (read_buffer_result),
    .out_if             (out_if),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] src_q[$];
  int           pulled;
  int           delivered;
  int           done_seen;
  int           last_cycle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out(input logic [W-1:0] v);
`ifdef RESULT_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(W'($urandom));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rbr"},   32'(read_buffer_result), 32'(0));
    check({tag, "_valid"}, 32'(out_if.out_valid),   32'(0));
    check({tag, "_data"},  32'(out_if.out_data),    32'(0));
    check({tag, "_index"}, 32'(out_if.out_index),   32'(0));
    check({tag, "_last"},  32'(out_if.out_last),    32'(0));
    check({tag, "_busy"},  32'(busy),               32'(0));
    check({tag, "_done"},  32'(done),               32'(0));
    check({tag, "_error"}, 32'(error),              32'(0));
  endtask

  task automatic do_start(input int cnt);
    @(negedge clk);
    start          = 1'b1;
    expected_count = CW'(cnt);
    @(negedge clk);
    start = 1'b0;
    #1;
    if (cnt != 0) begin
      check("start_busy",  32'(busy),  32'(1));
      check("start_error", 32'(error), 32'(0));
    end
  endtask

  // Cycle-by-cycle source/sink driver; the model is the ordered list of offered results.
  task automatic stream(input int cnt, input int n_avail, input int vld_pct, input int rdy_pct,
                        input int stall, input bit send_done, input int abort_at, input int budget);
    bit           done_sent = 1'b0;
    bit           prev_stall = 1'b0;
    bit           xfer_in;
    bit           xfer_out;
    logic [W-1:0] prev_data = '0;
    pulled    = 0;
    delivered = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      acc_psum_valid   = (pulled < n_avail) && ($urandom_range(99) < vld_pct);
      par_sum          = (pulled < n_avail) ? src_q[pulled] : W'($urandom);
      acc_done         = send_done && !done_sent && (pulled >= n_avail);
      out_if.out_ready = (cyc >= stall) && ($urandom_range(99) < rdy_pct);
      #1;
      if (done) begin
        done_seen++;
        last_cycle = cyc;
        break;
      end
      check("valid_vs_occupancy", 32'(out_if.out_valid), 32'(pulled > delivered));
      if (pulled - delivered == D) check("full_blocks_pull", 32'(read_buffer_result), 32'(0));
      if (pulled >= cnt) check("no_over_pull", 32'(read_buffer_result), 32'(0));
      if (out_if.out_valid && prev_stall) check("hold_data", 32'(out_if.out_data), 32'(prev_data));
      if (stall > 0 && cyc == stall) begin
        check("bp_pulled", 32'(pulled), 32'(D));
        check("bp_rbr_low", 32'(read_buffer_result), 32'(0));
      end
      xfer_in  = read_buffer_result && acc_psum_valid;
      xfer_out = out_if.out_valid && out_if.out_ready;
      if (xfer_out && delivered < pulled) begin
        check("out_data",  32'(out_if.out_data),  32'(model_out(src_q[delivered])));
        check("out_index", 32'(out_if.out_index), 32'(delivered));
        check("out_last",  32'(out_if.out_last),  32'(delivered == cnt - 1));
      end
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = out_if.out_data;
      @(posedge clk);
      if (xfer_in)  pulled++;
      if (xfer_out) delivered++;
      if (acc_done) done_sent = 1'b1;
      @(negedge clk);
      if (abort_at > 0 && pulled >= abort_at) break;
    end
    acc_psum_valid   = 1'b0;
    acc_done         = 1'b0;
    out_if.out_ready = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int n_exp);
    check({tag, "_done_seen"}, 32'(done_seen), 32'(1));
    check({tag, "_delivered"}, 32'(delivered), 32'(n_exp));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    @(negedge clk);
    #1;
    check({tag, "_done_single"}, 32'(done), 32'(0));
    check({tag, "_busy_after"},  32'(busy), 32'(0));
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    chip_en          = 1'b1;
    start            = 1'b0;
    expected_count   = '0;
    acc_psum_valid   = 1'b0;
    par_sum          = '0;
    acc_done         = 1'b0;
    out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Basic run with back-to-back offers and a ready sink.
    src_q.delete();
    src_q.push_back(W'(5));
    src_q.push_back(W'(15));
    src_q.push_back(W'(7));
    src_q.push_back(W'(105));
    do_start(4);
    stream(4, 4, 100, 100, 0, 1'b0, 0, 200);
    check("basic_throughput", 32'(last_cycle <= 4 + 4), 32'(1));
    finish_run("basic", 4);

    // Random data, random valid and ready.
    n = $urandom_range(40, 10);
    fill_random(n);
    do_start(n);
    stream(n, n, 70, 60, 0, 1'b0, 0, 1000);
    finish_run("random", n);

    // Back-pressure beyond FIFO depth.
    fill_random(70);
    do_start(70);
    stream(70, 70, 100, 100, 80, 1'b0, 0, 1000);
    finish_run("backpressure", 70);

    // Early accelerator done.
    fill_random(3);
    src_q[1] = W'(17'h1FFFD);
    do_start(8);
    stream(8, 3, 80, 70, 0, 1'b1, 0, 300);
    check("early_error", 32'(error), 32'(1));
    finish_run("early", 3);
    fill_random(2);
    do_start(2);
    stream(2, 2, 100, 100, 0, 1'b0, 0, 100);
    finish_run("after_early", 2);

    // Zero count.
    @(negedge clk);
    start          = 1'b1;
    expected_count = '0;
    #1;
    check("zero_rbr_cmd", 32'(read_buffer_result), 32'(0));
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done",  32'(done),               32'(1));
    check("zero_busy",  32'(busy),               32'(0));
    check("zero_rbr",   32'(read_buffer_result), 32'(0));
    @(negedge clk);
    #1;
    check("zero_done_single", 32'(done), 32'(0));

    // Accelerator valid while idle: one cycle is tolerated, two set the sticky error.
    @(negedge clk);
    acc_psum_valid = 1'b1;
    @(negedge clk);
    acc_psum_valid = 1'b0;
    @(negedge clk);
    #1;
    check("idle_valid_one", 32'(error), 32'(0));
    acc_psum_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    acc_psum_valid = 1'b0;
    #1;
    check("idle_valid_two", 32'(error), 32'(1));

    // Reset in the middle of a run, then a fresh short run.
    fill_random(5);
    do_start(5);
    stream(5, 5, 100, 0, 0, 1'b0, 2, 100);
    check("midrun_pulled", 32'(pulled), 32'(2));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("midrun_reset");
    rst = 1'b0;
    fill_random(2);
    do_start(2);
    stream(2, 2, 100, 100, 0, 1'b0, 0, 100);
    finish_run("after_reset", 2);

    // Negative result through the optional clamp.
    src_q.delete();
    src_q.push_back(W'(17'h1FFFD));
    src_q.push_back(W'(9));
    do_start(2);
    stream(2, 2, 100, 100, 0, 1'b0, 0, 100);
    finish_run("relu", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_result_reader.md
# conv_result_reader

Drains partial-sum results from the convolution accelerator's output buffer and delivers them downstream over a valid/ready stream. It owns the `read_buffer_result` pop strobe that the accelerator's result buffer expects. It counts results against a programmed total and buffers them in a local FIFO so downstream back-pressure never stalls the accelerator more than necessary. It sits between `conv_top_module`'s `par_sum`/`Done` outputs and the layer write-back path.

## Interface
- `PSUM_WIDTH`, 17 — width of `par_sum`; signed two's complement (8+8+1).
- `DEPTH`, 64 — local FIFO entries; power of two, ≥ 2.
- `COUNT_WIDTH`, 8 — width of result counters and `expected_count`.

- `clk` in 1 — rising-edge clock.
- `rst` in 1 — synchronous, active-high reset.
- `chip_en` in 1 — global enable; when low all state and outputs hold, and no transfer occurs on either side.
- `start` in 1 — single-cycle arm request.
- `expected_count` in COUNT_WIDTH — number of results for this run; sampled when `start` is accepted.
- `acc_psum_valid` in 1 — accelerator result buffer non-empty; `par_sum` is valid.
- `par_sum` in PSUM_WIDTH — accelerator result head.
- `acc_done` in 1 — accelerator `Done`.
- `read_buffer_result` out 1 — pop strobe. A transfer occurs on an edge where this and `acc_psum_valid` are both high.
- `out_valid` out 1, `out_ready` in 1 — downstream handshake.
- `out_data` out PSUM_WIDTH — result.
- `out_index` out COUNT_WIDTH — 0-based result ordinal.
- `out_last` out 1 — high with the final result of the run.
- `busy` out 1 — high whenever state is not IDLE.
- `done` out 1 — single-cycle completion pulse.
- `error` out 1 — sticky protocol error flag.

## Operation
- States:
  - IDLE → COLLECT when `start` is high and `expected_count` ≠ 0. At that point: latch the count, clear counters, clear `error`.
  - `start` with `expected_count` = 0 in IDLE: `done` pulses next cycle, and the state stays IDLE.
  - COLLECT → DRAIN when the pulled count reaches the latched count, or when `acc_done` rises with pulled < expected.
  - DRAIN → IDLE when the FIFO is empty and the last downstream handshake has completed. `done` pulses in the cycle after the transition.
- `start` while `busy` is ignored.
- `read_buffer_result` = (state == COLLECT) && FIFO not full && pulled < expected.
  - Derived from registered state only, never from `acc_psum_valid`.
- FIFO full: `read_buffer_result` is low even if a downstream pop occurs in the same cycle.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- `out_index` increments on each downstream handshake.
- `out_last` = FIFO head is the (latched count − 1)th result.
- `error` is set, and sticks until the next accepted `start`, on either:
  - `acc_done` in COLLECT before the count is reached;
  - `acc_psum_valid` high while IDLE for 2 or more consecutive cycles.
- `out_data` holds stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: `read_buffer_result`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0, `error`=0. FIFO is empty.
- `busy` rises in the cycle after `start` is accepted. `read_buffer_result` may be high from that same cycle.
- Latency: a result transferred at edge N is presented with `out_valid` high in the cycle after edge N (first-word fall-through FIFO).
- Sustained throughput: 1 result per cycle when `out_ready` is held high.
- `rst` mid-run returns everything to reset values at the next edge. In-flight FIFO data is discarded.

## Configuration
- `RESULT_RELU_EN`:
  - Defined: `out_data` is the FIFO head clamped to 0 when negative (MSB = 1). `out_index`, `out_last` and the counters are unaffected.
  - Undefined: `out_data` is the FIFO head passed through bit-exact.

## Structure
- Package `conv_reader_pkg`: state enum (IDLE, COLLECT, DRAIN) and default width constants (`PSUM_WIDTH_DEF` = 17, `COUNT_WIDTH_DEF` = 8).
- Sub-module `result_fifo`: synchronous first-word fall-through FIFO.
  - Parameters: width, DEPTH.
  - Ports: push, pop, full, empty, head.
  - Honors `chip_en`.
- Top level: FSM, counters, error logic and the optional RELU stage.

## Test plan
- **Basic run:** `expected_count`=4; `par_sum` = 5, 15, 7, 105 offered back-to-back; `out_ready`=1. Expect:
  - 4 outputs with `out_index` 0..3;
  - `out_last` only on 105;
  - `done` pulses once;
  - `busy` low afterwards.
- **Back-pressure:** `expected_count`=70, `DEPTH`=64, `out_ready`=0. Expect:
  - `read_buffer_result` drops after 64 transfers;
  - releasing `out_ready` resumes pulls;
  - all 70 results delivered in order.
- **Early `acc_done`:** `expected_count`=8; only 3 results, then `acc_done`. Expect:
  - `error`=1;
  - 3 outputs delivered;
  - `done` pulses;
  - next `start` clears `error`.
- **Zero count:** `start` with `expected_count`=0. Expect:
  - `done` pulses 1 cycle later;
  - no `read_buffer_result`;
  - `busy` stays 0.
- **Reset mid-run:** `rst` after 2 of 5 results. Expect:
  - all outputs at reset values next cycle;
  - a fresh `start` with `expected_count`=2 completes normally.
- **`RESULT_RELU_EN` defined:** `par_sum` = −3 (17'h1FFFD) then 9. Expect `out_data` = 0, then 9. Undefined: 17'h1FFFD, then 9.
